// File: rtl/parking_gate_arbiter.sv
// Shares the car-park barrier between the entrance and exit lanes and tracks
// lot occupancy. Lanes are granted one at a time with round-robin tie-breaking.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CLOSE_CYC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_sensor,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             timeout_err
);

  localparam int unsigned WaitW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CloseW = $clog2(CLOSE_CYC + 1);

  typedef enum logic [1:0] {
    StIdle,
    StOpenEntry,
    StOpenExit,
    StClosing
  } state_e;

  state_e              state_q;
  logic                last_exit_q;  // 1: exit lane won the most recent tie
  logic [WaitW-1:0]    wait_cnt_q;
  logic [CloseW-1:0]   close_cnt_q;

  logic                entry_ok;
  logic                exit_ok;
  logic                pick_entry;
  logic [CNT_W-1:0]    occ_next;

  always_comb begin
    entry_ok   = entry_req & ~full;
    exit_ok    = exit_req & ~empty;
    // Entry wins when it is the only eligible lane or exit won the last tie.
    pick_entry = entry_ok & (~exit_ok | last_exit_q);
    occ_next   = occupancy;
    if (state_q == StOpenEntry) begin
      occ_next = occupancy + CNT_W'(1);
    end else if (state_q == StOpenExit) begin
      occ_next = occupancy - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      last_exit_q <= 1'b1;
      wait_cnt_q  <= '0;
      close_cnt_q <= '0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      gate_open   <= 1'b0;
      occupancy   <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wait_cnt_q <= '0;
          if (pick_entry) begin
            state_q     <= StOpenEntry;
            entry_grant <= 1'b1;
            gate_open   <= 1'b1;
            if (exit_ok) last_exit_q <= 1'b0;
          end else if (exit_ok) begin
            state_q    <= StOpenExit;
            exit_grant <= 1'b1;
            gate_open  <= 1'b1;
            if (entry_ok) last_exit_q <= 1'b1;
          end
        end
        StOpenEntry, StOpenExit: begin
          if (pass_sensor) begin
            occupancy   <= occ_next;
            full        <= (occ_next == CNT_W'(CAPACITY));
            empty       <= (occ_next == '0);
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            gate_open   <= 1'b0;
            close_cnt_q <= '0;
            state_q     <= StClosing;
          end else if (wait_cnt_q == WaitW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            gate_open   <= 1'b0;
            close_cnt_q <= '0;
            state_q     <= StClosing;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StClosing: begin
          if (close_cnt_q == CloseW'(CLOSE_CYC - 1)) begin
            state_q <= StIdle;
          end else begin
            close_cnt_q <= close_cnt_q + CloseW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: expected grants are queued as
// stimulus is applied and popped as the DUT raises each grant.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       pass_sensor = 1'b0;
  logic       entry_grant, exit_grant, gate_open, full, empty, timeout_err;
  logic [3:0] occupancy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int lane;  // 1 = entry, 2 = exit
    int occ;   // occupancy expected after the car passes
  } exp_t;
  exp_t exp_q[$];

  parking_gate_arbiter #(
    .CAPACITY   (8),
    .CNT_W      (4),
    .TIMEOUT_CYC(16),
    .CLOSE_CYC  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .pass_sensor(pass_sensor),
    .entry_grant(entry_grant),
    .exit_grant (exit_grant),
    .gate_open  (gate_open),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    pass_sensor = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a grant; returns 0 if none appeared.
  task automatic wait_grant(output int lane);
    lane = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (entry_grant) begin lane = 1; break; end
      if (exit_grant) begin lane = 2; break; end
    end
  endtask

  task automatic pulse_pass();
    pass_sensor = 1'b1;
    @(negedge clk);
    pass_sensor = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({entry_grant, exit_grant, gate_open, full, empty, timeout_err} !== 6'b000010
        || occupancy !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got g=%b%b open=%b full=%b empty=%b to=%b occ=%0d, want 000 0 1 0 occ=0",
               entry_grant, exit_grant, gate_open, full, empty, timeout_err, occupancy);
    end
    do_reset();
  endtask

  task automatic test_single_entry();
    int lane;
    int bad;
    do_reset();
    entry_req = 1'b1;
    wait_grant(lane);
    tests_run++;
    if (lane !== 1 || gate_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: got lane=%0d open=%b, want lane=1 open=1", lane, gate_open);
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (!(entry_grant && gate_open && !exit_grant)) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_hold: got %0d cycles without grant, want 0", bad);
    end
    entry_req = 1'b0;
    pulse_pass();
    tests_run++;
    if (gate_open !== 1'b0 || entry_grant !== 1'b0 || occupancy !== 4'd1 || empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pass: got open=%b grant=%b occ=%0d empty=%b, want 0 0 1 0",
               gate_open, entry_grant, occupancy, empty);
    end
    entry_req = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (gate_open || entry_grant || exit_grant) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_closing: got %0d open cycles in closing, want 0", bad);
    end
    entry_req = 1'b0;
  endtask

  task automatic test_round_robin();
    int lane;
    do_reset();
    entry_req = 1'b1;
    exp_q.push_back('{1, 1});
    exp_q.push_back('{1, 2});
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_grant(lane);
      pulse_pass();
      tests_run++;
      if (lane !== e.lane || int'(occupancy) !== e.occ) begin
        tests_failed++;
        $display("FAIL rr_fill%0d: got lane=%0d occ=%0d, want lane=%0d occ=%0d",
                 k, lane, occupancy, e.lane, e.occ);
      end
    end
    exit_req = 1'b1;
    exp_q.push_back('{1, 3});
    exp_q.push_back('{2, 2});
    exp_q.push_back('{1, 3});
    exp_q.push_back('{2, 2});
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_grant(lane);
      pulse_pass();
      tests_run++;
      if (lane !== e.lane || int'(occupancy) !== e.occ) begin
        tests_failed++;
        $display("FAIL rr_alt%0d: got lane=%0d occ=%0d, want lane=%0d occ=%0d",
                 k, lane, occupancy, e.lane, e.occ);
      end
    end
    entry_req = 1'b0;
    exit_req = 1'b0;
  endtask

  task automatic test_full();
    int lane;
    int opens;
    do_reset();
    entry_req = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back('{1, k});
    for (int k = 0; k < 8; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_grant(lane);
      pulse_pass();
      tests_run++;
      if (lane !== e.lane || int'(occupancy) !== e.occ) begin
        tests_failed++;
        $display("FAIL full_fill%0d: got lane=%0d occ=%0d, want lane=%0d occ=%0d",
                 k, lane, occupancy, e.lane, e.occ);
      end
    end
    opens = 0;
    repeat (30) begin
      @(negedge clk);
      if (gate_open || entry_grant) opens++;
    end
    tests_run++;
    if (full !== 1'b1 || opens !== 0) begin
      tests_failed++;
      $display("FAIL full_block: got full=%b open_cycles=%0d, want full=1 open_cycles=0",
               full, opens);
    end
    exit_req = 1'b1;
    exp_q.push_back('{2, 7});
    exp_q.push_back('{1, 8});
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_grant(lane);
      pulse_pass();
      tests_run++;
      if (lane !== e.lane || int'(occupancy) !== e.occ) begin
        tests_failed++;
        $display("FAIL full_drain%0d: got lane=%0d occ=%0d, want lane=%0d occ=%0d",
                 k, lane, occupancy, e.lane, e.occ);
      end
    end
    tests_run++;
    if (full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_flag: got full=%b, want 1", full);
    end
    entry_req = 1'b0;
    exit_req = 1'b0;
  endtask

  task automatic test_empty_exit();
    int opens;
    do_reset();
    exit_req = 1'b1;
    opens = 0;
    repeat (20) begin
      @(negedge clk);
      if (gate_open || exit_grant) opens++;
    end
    tests_run++;
    if (opens !== 0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_exit: got open_cycles=%0d empty=%b, want 0 and 1", opens, empty);
    end
    exit_req = 1'b0;
  endtask

  task automatic test_timeout();
    int lane;
    int bad;
    do_reset();
    entry_req = 1'b1;
    wait_grant(lane);
    entry_req = 1'b0;
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (!gate_open || timeout_err) bad++;
    end
    @(negedge clk);
    tests_run++;
    if (lane !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL timeout_hold: got lane=%0d bad_cycles=%0d, want lane=1 bad=0", lane, bad);
    end
    tests_run++;
    if (timeout_err !== 1'b1 || gate_open !== 1'b0 || occupancy !== 4'd0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: got to=%b open=%b occ=%0d, want 1 0 0",
               timeout_err, gate_open, occupancy);
    end
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b0 || gate_open !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_width: got to=%b open=%b, want 0 0", timeout_err, gate_open);
    end
  endtask

  task automatic test_reset_mid_exit();
    int lane;
    do_reset();
    entry_req = 1'b1;
    repeat (2) begin
      wait_grant(lane);
      pulse_pass();
    end
    exit_req = 1'b1;
    wait_grant(lane);
    pulse_pass();
    tests_run++;
    if (lane !== 1 || occupancy !== 4'd3) begin
      tests_failed++;
      $display("FAIL pre_reset_tie: got lane=%0d occ=%0d, want 1 3", lane, occupancy);
    end
    entry_req = 1'b0;
    wait_grant(lane);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (lane !== 2 || gate_open !== 1'b0 || exit_grant !== 1'b0 || occupancy !== 4'd0
        || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: got lane=%0d open=%b xg=%b occ=%0d empty=%b, want 2 0 0 0 1",
               lane, gate_open, exit_grant, occupancy, empty);
    end
    exit_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    entry_req = 1'b1;
    exp_q.push_back('{1, 1});
    exp_q.push_back('{1, 2});
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      wait_grant(lane);
      pulse_pass();
      exit_req = 1'b1;
      tests_run++;
      if (lane !== e.lane || int'(occupancy) !== e.occ) begin
        tests_failed++;
        $display("FAIL post_reset%0d: got lane=%0d occ=%0d, want lane=%0d occ=%0d",
                 k, lane, occupancy, e.lane, e.occ);
      end
    end
    entry_req = 1'b0;
    exit_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_round_robin();
    test_full();
    test_empty_exit();
    test_timeout();
    test_reset_mid_exit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
